// File: rtl/lc2k_exec_unit.sv
// LC2K execute stage: operand-B select, add/nor ALU, beq compare and sticky halt with run enable.
// Optional cycle counter output enabled by defining LC2K_CYCLE_COUNT_EN.
module lc2k_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_val_a,
    input  logic [WIDTH-1:0] reg_b_value,
    input  logic [15:0]      offset,
    input  logic             ctrl_alu_val_b,
    input  logic             ctrl_operation,
    input  logic             ctrl_beq,
    input  logic             ctrl_halt,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             branch_taken,
    output logic             halted,
    output logic             run_en
`ifdef LC2K_CYCLE_COUNT_EN
    ,
    output logic [31:0]      cycle_count
`endif
);

    typedef enum logic [0:0] {
        RUN_ST    = 1'b0,
        HALTED_ST = 1'b1
    } exec_state_t;

    exec_state_t      state_r;
    exec_state_t      state_nxt_s;
    logic [WIDTH-1:0] offset_ext_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             operands_eq_s;
    logic             running_s;
    logic [WIDTH-1:0] alu_result_r;
    logic             zero_r;
    logic             branch_taken_r;

    assign offset_ext_s  = {{(WIDTH-16){offset[15]}}, offset};
    assign operands_eq_s = (alu_val_a == reg_b_value);
    assign running_s     = (state_r == RUN_ST);

    // Operand-B select and ALU function; carry out of the add is dropped.
    always_comb begin
        op_b_s    = reg_b_value;
        alu_res_s = {WIDTH{1'b0}};
        if (ctrl_alu_val_b) begin
            op_b_s = offset_ext_s;
        end else begin
            op_b_s = reg_b_value;
        end
        case (ctrl_operation)
            1'b0:    alu_res_s = alu_val_a + op_b_s;
            1'b1:    alu_res_s = ~(alu_val_a | op_b_s);
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Next-state logic: only reset leaves HALTED.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN_ST: begin
                if (ctrl_halt) begin
                    state_nxt_s = HALTED_ST;
                end else begin
                    state_nxt_s = RUN_ST;
                end
            end
            HALTED_ST: state_nxt_s = HALTED_ST;
            default:   state_nxt_s = RUN_ST;
        endcase
    end

    // Halt state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN_ST;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result registers; a halt instruction leaves the previous ALU result in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_r   <= {WIDTH{1'b0}};
            zero_r         <= 1'b1;
            branch_taken_r <= 1'b0;
        end else if (running_s) begin
            if (ctrl_halt) begin
                branch_taken_r <= 1'b0;
            end else begin
                alu_result_r   <= alu_res_s;
                zero_r         <= (alu_res_s == {WIDTH{1'b0}});
                branch_taken_r <= ctrl_beq & operands_eq_s;
            end
        end
    end

    assign alu_result   = alu_result_r;
    assign zero         = zero_r;
    assign branch_taken = branch_taken_r;
    assign halted       = (state_r == HALTED_ST);
    assign run_en       = ~halted;

`ifdef LC2K_CYCLE_COUNT_EN
    logic [31:0] cycle_count_r;

    // Counts every running cycle, including the one that samples the halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_r <= 32'd0;
        end else if (running_s) begin
            cycle_count_r <= cycle_count_r + 32'd1;
        end
    end

    assign cycle_count = cycle_count_r;
`endif

endmodule

// File: tb/tb_lc2k_exec_unit.sv
// Self-checking bench for lc2k_exec_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the execute stage.
module tb_lc2k_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_val_a;
    logic [31:0] reg_b_value;
    logic [15:0] offset;
    logic        ctrl_alu_val_b;
    logic        ctrl_operation;
    logic        ctrl_beq;
    logic        ctrl_halt;
    logic [31:0] alu_result;
    logic        zero;
    logic        branch_taken;
    logic        halted;
    logic        run_en;
`ifdef LC2K_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [31:0] m_alu;
    logic        m_zero;
    logic        m_bt;
    logic        m_halted;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    lc2k_exec_unit #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_val_a      (alu_val_a),
        .reg_b_value    (reg_b_value),
        .offset         (offset),
        .ctrl_alu_val_b (ctrl_alu_val_b),
        .ctrl_operation (ctrl_operation),
        .ctrl_beq       (ctrl_beq),
        .ctrl_halt      (ctrl_halt),
        .alu_result     (alu_result),
        .zero           (zero),
        .branch_taken   (branch_taken),
        .halted         (halted),
        .run_en         (run_en)
`ifdef LC2K_CYCLE_COUNT_EN
        ,
        .cycle_count    (cycle_count)
`endif
    );

    function automatic logic [35:0] obs_vec();
        return {alu_result, zero, branch_taken, halted, run_en};
    endfunction

    function automatic logic [35:0] exp_vec();
        return {m_alu, m_zero, m_bt, m_halted, ~m_halted};
    endfunction

    // Apply one instruction's inputs, clock once, update the model, sample after the edge.
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] rb,
                        input logic [15:0] off, input logic selb, input logic op,
                        input logic beq, input logic halt);
        logic [31:0] opb;
        logic [31:0] res;
        rst = r; alu_val_a = a; reg_b_value = rb; offset = off;
        ctrl_alu_val_b = selb; ctrl_operation = op; ctrl_beq = beq; ctrl_halt = halt;
        @(posedge clk);
        if (r) begin
            m_alu = 32'h0; m_zero = 1'b1; m_bt = 1'b0; m_halted = 1'b0; m_cnt = 32'h0;
        end else if (!m_halted) begin
            m_cnt = m_cnt + 32'd1;
            if (halt) begin
                m_halted = 1'b1;
                m_bt     = 1'b0;
            end else begin
                opb    = selb ? 32'($signed(off)) : rb;
                res    = op ? ~(a | opb) : (a + opb);
                m_alu  = res;
                m_zero = (res == 32'h0);
                m_bt   = beq && (a == rb);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, $urandom, $urandom, 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (obs_vec() !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b1}) $display("FAIL reset_state got=%h want=%h", obs_vec(), {32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        else n_pass++;
`ifdef LC2K_CYCLE_COUNT_EN
        n_checks++;
        if (cycle_count !== 32'h0) $display("FAIL reset_count got=%h want=0", cycle_count);
        else n_pass++;
`endif
    endtask

    task automatic test_add_neg_offset();
        step(1'b0, 32'h5, 32'h12345678, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (alu_result !== 32'h3 || zero !== 1'b0) $display("FAIL add_neg_offset got=%h/%b want=00000003/0", alu_result, zero);
        else n_pass++;
    endtask

    task automatic test_nor();
        step(1'b0, 32'h0F0F0F0F, 32'hF0F00000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (alu_result !== 32'h0000F0F0 || zero !== 1'b0) $display("FAIL nor got=%h/%b want=0000f0f0/0", alu_result, zero);
        else n_pass++;
    endtask

    task automatic test_wrap();
        step(1'b0, 32'hFFFFFFFF, 32'h1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (alu_result !== 32'h0 || zero !== 1'b1) $display("FAIL add_wrap got=%h/%b want=00000000/1", alu_result, zero);
        else n_pass++;
    endtask

    task automatic test_beq();
        step(1'b0, 32'h7, 32'h7, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (branch_taken !== 1'b1 || alu_result !== 32'hA) $display("FAIL beq_equal got=%b/%h want=1/0000000a", branch_taken, alu_result);
        else n_pass++;
        step(1'b0, 32'h7, 32'h8, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (branch_taken !== 1'b0) $display("FAIL beq_unequal got=%b want=0", branch_taken);
        else n_pass++;
    endtask

    task automatic test_halt_sticky();
        logic [31:0] cnt_hold;
        step(1'b0, 32'h1, 32'h2, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h9, 32'h9, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (obs_vec() !== {32'h3, 1'b0, 1'b0, 1'b1, 1'b0}) $display("FAIL halt_enter got=%h want=%h", obs_vec(), {32'h3, 1'b0, 1'b0, 1'b1, 1'b0});
        else n_pass++;
`ifdef LC2K_CYCLE_COUNT_EN
        cnt_hold = cycle_count;
        n_checks++;
        if (cycle_count !== m_cnt) $display("FAIL halt_count got=%h want=%h", cycle_count, m_cnt);
        else n_pass++;
`else
        cnt_hold = 32'h0;
`endif
        for (int i = 0; i < 5; i++) begin
            step(1'b0, $urandom, $urandom, 16'($urandom), 1'($urandom), 1'b0, 1'b1, 1'($urandom));
            n_checks++;
            if (obs_vec() !== {32'h3, 1'b0, 1'b0, 1'b1, 1'b0}) $display("FAIL halt_hold%0d got=%h want=%h", i, obs_vec(), {32'h3, 1'b0, 1'b0, 1'b1, 1'b0});
            else n_pass++;
`ifdef LC2K_CYCLE_COUNT_EN
            n_checks++;
            if (cycle_count !== cnt_hold) $display("FAIL halt_count_frozen%0d got=%h want=%h", i, cycle_count, cnt_hold);
            else n_pass++;
`endif
        end
        step(1'b1, 32'h1, 32'h1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_vec() !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b1}) $display("FAIL halt_exit_reset got=%h want=%h", obs_vec(), {32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
        else n_pass++;
    endtask

    task automatic test_reset_with_halt();
        step(1'b0, 32'h4, 32'h4, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h4, 32'h4, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (halted !== 1'b0 || branch_taken !== 1'b0 || run_en !== 1'b1) $display("FAIL reset_with_halt got=%b%b%b want=001", halted, branch_taken, run_en);
        else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 32'h1, 32'h1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef LC2K_CYCLE_COUNT_EN
            n_checks++;
            if (cycle_count !== 32'(i)) $display("FAIL count_after_reset%0d got=%h want=%h", i, cycle_count, 32'(i));
            else n_pass++;
`endif
        end
        n_checks++;
        if (alu_result !== 32'h2 || halted !== 1'b0) $display("FAIL run_after_reset got=%h/%b want=00000002/0", alu_result, halted);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] rb;
        for (int i = 0; i < 400; i++) begin
            a  = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? a : $urandom;
            step(($urandom_range(0, 31) == 0), a, rb, 16'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 15) == 0));
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random%0d got=%h want=%h", i, obs_vec(), exp_vec());
            else n_pass++;
`ifdef LC2K_CYCLE_COUNT_EN
            n_checks++;
            if (cycle_count !== m_cnt) $display("FAIL random_count%0d got=%h want=%h", i, cycle_count, m_cnt);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        rst = 1'b1; alu_val_a = 32'h0; reg_b_value = 32'h0; offset = 16'h0;
        ctrl_alu_val_b = 1'b0; ctrl_operation = 1'b0; ctrl_beq = 1'b0; ctrl_halt = 1'b0;
        m_alu = 32'h0; m_zero = 1'b1; m_bt = 1'b0; m_halted = 1'b0; m_cnt = 32'h0;
        test_reset();
        test_add_neg_offset();
        test_nor();
        test_wrap();
        test_beq();
        test_halt_sticky();
        test_reset_with_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
